// File: rtl/lfsr_rand_range.sv
// On-demand pseudo-random source: Galois LFSR stepped only while drawing,
// rejection sampling into 0..RANGE-1 with a bounded number of attempts.
module lfsr_rand_range #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
    parameter int               OUT_W     = 2,
    parameter int               RANGE     = 4,
    parameter int               MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    output logic             busy,
    output logic             rand_valid,
    output logic [OUT_W-1:0] rand_out
);

    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [OUT_W:0]   RANGE_W  = (OUT_W + 1)'(RANGE);
    localparam logic [OUT_W-1:0] RANGE_LO = RANGE_W[OUT_W-1:0];
    localparam logic [TW-1:0]    LAST_TRY = TW'(MAX_TRIES - 1);

    typedef enum logic {
        IDLE,
        DRAW
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
    logic [TW-1:0]    tries_q, tries_d;
    logic [OUT_W-1:0] cand, out_d;
    logic             valid_d;
    logic             cand_ok;

    assign cand      = lfsr_q[OUT_W-1:0];
    assign cand_ok   = {1'b0, cand} < RANGE_W;
    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    assign busy      = (state_q == DRAW);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        tries_d = tries_q;
        out_d   = rand_out;
        valid_d = 1'b0;
        if (seed_load) begin
            // a zero seed would lock the LFSR up, so fall back to SEED
            lfsr_d  = (seed_in == '0) ? SEED : seed_in;
            state_d = IDLE;
            tries_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        state_d = DRAW;
                        tries_d = '0;
                    end
                end
                DRAW: begin
                    lfsr_d  = lfsr_step;
                    tries_d = tries_q + 1'b1;
                    if (cand_ok) begin
                        out_d   = cand;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else if (tries_q == LAST_TRY) begin
                        // folded value is below RANGE since RANGE > 2^(OUT_W-1)
                        out_d   = cand - RANGE_LO;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            tries_q    <= '0;
            rand_out   <= '0;
            rand_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            tries_q    <= tries_d;
            rand_out   <= out_d;
            rand_valid <= valid_d;
        end
    end

endmodule
